// File: rtl/simd_instr_host.sv
// Host-side instruction buffer and run controller for the SIMD processor top.
// Serves INSTR_AXI from PC_AXI, sequences START/STOP and reports run status.
module simd_instr_host #(
  parameter int N       = 512,
  parameter int PC_W    = $clog2(N),
  parameter int TIMEOUT = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            LOAD_EN,
  input  logic [PC_W-1:0] LOAD_ADDR,
  input  logic [31:0]     LOAD_DATA,
  input  logic            RUN_REQ,
  input  logic [PC_W-1:0] PC_AXI,
  output logic [31:0]     INSTR_AXI,
  output logic            START_SIGNAL,
  input  logic            STOP_SIGNAL,
  output logic            BUSY,
  output logic            DONE,
  output logic            TIMED_OUT,
  output logic            LOAD_ERR,
  output logic [31:0]     CYCLE_COUNT,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [PC_W:0] DEPTH   = N[PC_W:0];
  localparam logic [31:0]   TO_LAST = 32'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] mem [N];
  logic        in_run;
  logic        load_ok;
  logic        timeout_hit;
  logic [31:0] count_inc;

  assign dbg_state   = state;
  assign in_run      = (state == S_ARM) || (state == S_RUN);
  assign load_ok     = LOAD_EN && !in_run && ({1'b0, LOAD_ADDR} < DEPTH);
  assign timeout_hit = (TIMEOUT > 0) && (CYCLE_COUNT == TO_LAST);
  assign count_inc   = (CYCLE_COUNT == 32'hFFFF_FFFF) ? CYCLE_COUNT : CYCLE_COUNT + 32'd1;

  // Buffer storage is not reset so it can map onto block RAM.
  always_ff @(posedge CLK) begin
    if (load_ok) mem[LOAD_ADDR] <= LOAD_DATA;
  end

  // Run handshake: START rises the cycle after an accepted RUN_REQ and stays high
  // until a STOP is seen in RUN; STOP must first be observed low (ARM) so a level
  // left over from the previous run cannot end the new one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      INSTR_AXI    <= '0;
      START_SIGNAL <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      TIMED_OUT    <= 1'b0;
      LOAD_ERR     <= 1'b0;
      CYCLE_COUNT  <= '0;
    end else begin
      INSTR_AXI <= ({1'b0, PC_AXI} < DEPTH) ? mem[PC_AXI] : '0;
      if (LOAD_EN && in_run) LOAD_ERR <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (RUN_REQ) begin
            state        <= S_ARM;
            START_SIGNAL <= 1'b1;
            BUSY         <= 1'b1;
            DONE         <= 1'b0;
            TIMED_OUT    <= 1'b0;
            LOAD_ERR     <= 1'b0;
            CYCLE_COUNT  <= '0;
          end
        end
        S_ARM: begin
          CYCLE_COUNT <= count_inc;
          if (timeout_hit) begin
            state        <= S_DONE;
            START_SIGNAL <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b1;
            TIMED_OUT    <= 1'b1;
          end else if (!STOP_SIGNAL) begin
            state <= S_RUN;
          end
        end
        default: begin
          CYCLE_COUNT <= count_inc;
          if (STOP_SIGNAL || timeout_hit) begin
            state        <= S_DONE;
            START_SIGNAL <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b1;
            TIMED_OUT    <= !STOP_SIGNAL;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simd_instr_host.sv
// Bench for simd_instr_host: dut_a (N=512, no timeout) and dut_b (N=12, TIMEOUT=8)
// share stimulus; reads, runs, timeouts, load errors and async reset are checked.
module tb_simd_instr_host;

  localparam int TO_B = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [8:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        run_req = 1'b0;
  logic [8:0]  pc_axi = '0;
  logic        stop = 1'b0;

  logic [31:0] instr_a, instr_b, count_a, count_b;
  logic        start_a, start_b, busy_a, busy_b, done_a, done_b;
  logic        to_a, to_b, err_a, err_b;
  logic [1:0]  st_a, st_b;

  simd_instr_host #(.N(512), .TIMEOUT(0)) dut_a (
    .CLK(clk), .RST(rst), .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data),
    .RUN_REQ(run_req), .PC_AXI(pc_axi), .INSTR_AXI(instr_a), .START_SIGNAL(start_a),
    .STOP_SIGNAL(stop), .BUSY(busy_a), .DONE(done_a), .TIMED_OUT(to_a), .LOAD_ERR(err_a),
    .CYCLE_COUNT(count_a), .dbg_state(st_a)
  );

  simd_instr_host #(.N(12), .TIMEOUT(TO_B)) dut_b (
    .CLK(clk), .RST(rst), .LOAD_EN(load_en), .LOAD_ADDR(load_addr[3:0]), .LOAD_DATA(load_data),
    .RUN_REQ(run_req), .PC_AXI(pc_axi[3:0]), .INSTR_AXI(instr_b), .START_SIGNAL(start_b),
    .STOP_SIGNAL(stop), .BUSY(busy_b), .DONE(done_b), .TIMED_OUT(to_b), .LOAD_ERR(err_b),
    .CYCLE_COUNT(count_b), .dbg_state(st_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem[int];
  int addr_q[$];

  typedef struct {
    int stale;
    int run_len;
    int exp_cnt_a;
    int exp_cnt_b;
    int exp_to_b;
  } run_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic load_word(input int addr, input logic [31:0] data);
    load_en = 1'b1; load_addr = 9'(addr); load_data = data;
    @(negedge clk);
    load_en = 1'b0;
    ref_mem[addr] = data;
    addr_q.push_back(addr);
  endtask

  task automatic read_check(input string name, input int pc, input logic [31:0] exp);
    pc_axi = 9'(pc);
    exp_q.push_back(exp);
    @(negedge clk);
    check(name, instr_a, exp_q.pop_front());
  endtask

  // Accepts a run, holds STOP high for `stale` cycles, low for `run_len`, then high.
  task automatic run_seq(input int stale, input int run_len, output int highs);
    int t;
    t = stale + run_len + 1;
    highs = 0;
    run_req = 1'b1;
    stop = (stale > 0);
    @(negedge clk);
    run_req = 1'b0;
    for (int c = 1; c <= t; c++) begin
      if (start_a) highs++;
      stop = (c <= stale) ? 1'b1 : (c <= stale + run_len) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    if (start_a) highs++;
  endtask

  // Run length is the number of cycles from acceptance to the first STOP seen after a low.
  task automatic run_model(input int stale, input int run_len,
                           output int cnt_a, output int cnt_b, output int tmo_b);
    int len;
    len = stale + run_len + 1;
    cnt_a = len;
    cnt_b = (len > TO_B) ? TO_B : len;
    tmo_b = (len > TO_B) ? 1 : 0;
  endtask

  task automatic check_run(input string tag, input int highs, input int cnt_a,
                           input int cnt_b, input int tmo_b);
    check({tag, "_start_cycles"}, 32'(highs), 32'(cnt_a));
    check({tag, "_done_a"}, {31'd0, done_a}, 32'd1);
    check({tag, "_busy_a"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_count_a"}, count_a, 32'(cnt_a));
    check({tag, "_to_a"}, {31'd0, to_a}, 32'd0);
    check({tag, "_count_b"}, count_b, 32'(cnt_b));
    check({tag, "_to_b"}, {31'd0, to_b}, 32'(tmo_b));
    check({tag, "_done_b"}, {31'd0, done_b}, 32'd1);
  endtask

  initial begin
    run_vec_t vecs[4];
    int highs, ca, cb, tb;
    vecs[0] = '{stale: 0, run_len: 10, exp_cnt_a: 11, exp_cnt_b: 8, exp_to_b: 1};
    vecs[1] = '{stale: 3, run_len: 5,  exp_cnt_a: 9,  exp_cnt_b: 8, exp_to_b: 1};
    vecs[2] = '{stale: 0, run_len: 7,  exp_cnt_a: 8,  exp_cnt_b: 8, exp_to_b: 0};
    vecs[3] = '{stale: 2, run_len: 3,  exp_cnt_a: 6,  exp_cnt_b: 6, exp_to_b: 0};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_instr", instr_a, 32'd0);
    check("rst_start", {31'd0, start_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_to", {31'd0, to_a}, 32'd0);
    check("rst_err", {31'd0, err_a}, 32'd0);
    check("rst_count", count_a, 32'd0);

    // Program load and reads
    load_word(0, 32'h1111_1111);
    load_word(1, 32'h2222_2222);
    load_word(2, 32'h3333_3333);
    load_word(3, 32'h4444_4444);
    read_check("read_pc2", 2, 32'h3333_3333);
    read_check("read_pc0", 0, 32'h1111_1111);

    // Write and read of the same address in one cycle returns the old word
    load_en = 1'b1; load_addr = 9'd3; load_data = 32'h5555_5555; pc_axi = 9'd3;
    @(negedge clk);
    load_en = 1'b0;
    check("same_cycle_old", instr_a, 32'h4444_4444);
    @(negedge clk);
    check("same_cycle_new", instr_a, 32'h5555_5555);
    load_word(3, 32'h4444_4444);

    // Small-depth instance: last valid word and out-of-range pc
    load_word(11, 32'hB0B0_B0B0);
    pc_axi = 9'd11;
    @(negedge clk);
    check("b_last_word", instr_b, 32'hB0B0_B0B0);
    pc_axi = 9'd13;
    @(negedge clk);
    check("b_pc_out_of_range", instr_b, 32'd0);

    // Table-driven runs: normal, stale stop, stop on the timeout cycle, short
    foreach (vecs[i]) begin
      run_seq(vecs[i].stale, vecs[i].run_len, highs);
      check_run($sformatf("vec%0d", i), highs, vecs[i].exp_cnt_a, vecs[i].exp_cnt_b,
                vecs[i].exp_to_b);
    end

    // Run accepted with a same-cycle load, then a load while busy
    run_req = 1'b1; stop = 1'b0;
    load_en = 1'b1; load_addr = 9'd5; load_data = 32'h5A5A_0005;
    @(negedge clk);
    run_req = 1'b0; load_en = 1'b0;
    ref_mem[5] = 32'h5A5A_0005;
    check("busy_after_req", {31'd0, busy_a}, 32'd1);
    load_en = 1'b1; load_addr = 9'd0; load_data = 32'hDEAD_BEEF;
    @(negedge clk);
    load_en = 1'b0;
    check("load_err_set", {31'd0, err_a}, 32'd1);
    stop = 1'b1;
    @(negedge clk);
    check("load_err_held", {31'd0, err_a}, 32'd1);
    read_check("buf0_kept", 0, 32'h1111_1111);
    read_check("req_load_done", 5, 32'h5A5A_0005);
    run_seq(0, 2, highs);
    check("load_err_cleared", {31'd0, err_a}, 32'd0);

    // Randomized loads, reads and runs against the reference model
    for (int it = 0; it < 25; it++) begin
      int a, p, s, r;
      logic [31:0] d;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        a = int'($urandom_range(4, 511));
        d = $urandom;
        load_word(a, d);
      end
      for (int k = 0; k < 2; k++) begin
        p = addr_q[$urandom_range(0, addr_q.size() - 1)];
        read_check($sformatf("rand_read_%0d", p), p, ref_mem[p]);
      end
      s = int'($urandom_range(0, 3));
      r = int'($urandom_range(1, 15));
      run_seq(s, r, highs);
      run_model(s, r, ca, cb, tb);
      check_run($sformatf("rand%0d", it), highs, ca, cb, tb);
    end

    // Asynchronous reset in the middle of a run
    run_req = 1'b1; stop = 1'b0;
    @(negedge clk);
    run_req = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_start", {31'd0, start_a}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_start", {31'd0, start_a}, 32'd0);
    check("async_busy", {31'd0, busy_a}, 32'd0);
    check("async_done", {31'd0, done_a}, 32'd0);
    check("async_count", count_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    read_check("buf_retained", 2, 32'h3333_3333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/simd_instr_host.md
Name: simd_instr_host

Overview:
- Host-side counterpart of the SIMD processor top's instruction and GPIO interface.
- Holds the instruction program in an internal N-word buffer. A host loads the program through a simple write port.
- During a run, serves INSTR_AXI from the processor's PC_AXI, drives START_SIGNAL, and waits for STOP_SIGNAL.
- Reports run status, cycle count and timeout. Sits between the PS/host glue and the processor top.

Parameters:
- N, 512, instruction buffer depth in 32-bit words; must match the processor's N.
- PC_W, $clog2(N), program counter / load address width.
- TIMEOUT, 0, maximum run cycles before forced abort; 0 disables the timeout.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- LOAD_EN  in  1  write LOAD_DATA into buffer[LOAD_ADDR] this cycle.
- LOAD_ADDR  in  PC_W  load address.
- LOAD_DATA  in  32  instruction word.
- RUN_REQ  in  1  single-cycle request to start a program run.
- PC_AXI  in  PC_W  processor program counter.
- INSTR_AXI  out  32  instruction at PC_AXI, registered.
- START_SIGNAL  out  1  start to processor.
- STOP_SIGNAL  in  1  processor finished.
- BUSY  out  1  run in progress (ARM or RUN state).
- DONE  out  1  last run finished; held until next accepted RUN_REQ.
- TIMED_OUT  out  1  last run ended by timeout.
- LOAD_ERR  out  1  sticky: a load was attempted while BUSY.
- CYCLE_COUNT  out  32  cycles spent in ARM+RUN during the last or current run.

Behaviour:
- Reset (async, immediate): state=IDLE. INSTR_AXI=0, START_SIGNAL=0, BUSY=0, DONE=0, TIMED_OUT=0, LOAD_ERR=0, CYCLE_COUNT=0. Buffer contents are not reset (undefined until loaded).
- Buffer read: INSTR_AXI <= buffer[PC_AXI] every cycle in all states, so read latency is 1 cycle. PC_AXI values >= N return 0.
- Buffer write: LOAD_EN in IDLE or DONE writes buffer[LOAD_ADDR]; LOAD_ADDR >= N is ignored.
  - Same-cycle write and read of one address returns the old word; the new word appears the next cycle.
  - LOAD_EN while BUSY: write dropped, LOAD_ERR set. LOAD_ERR clears only on reset or on an accepted RUN_REQ.
- States:
  - IDLE/DONE: RUN_REQ -> ARM. Also clears DONE, TIMED_OUT, LOAD_ERR and CYCLE_COUNT, and sets START_SIGNAL=1 and BUSY=1 (registered, visible the cycle after RUN_REQ).
  - RUN_REQ and LOAD_EN in the same cycle: the load is performed and the run is accepted.
  - ARM: START_SIGNAL=1. Waits for STOP_SIGNAL=0, so a stale STOP from a previous run is ignored. STOP=0 -> RUN.
  - RUN: START_SIGNAL=1. STOP_SIGNAL=1 -> DONE: START_SIGNAL=0, BUSY=0, DONE=1 on the next edge.
  - RUN_REQ while BUSY is ignored.
- CYCLE_COUNT increments by 1 each cycle in ARM or RUN, saturates at 0xFFFFFFFF, and holds in DONE.
- Timeout (TIMEOUT>0): the cycle in which CYCLE_COUNT==TIMEOUT-1 in ARM/RUN transitions to DONE with TIMED_OUT=1 and START_SIGNAL=0. If STOP_SIGNAL=1 in RUN on that same cycle, the STOP wins and TIMED_OUT=0.
- Reset mid-run returns to IDLE immediately; START_SIGNAL drops asynchronously.

Test Plan:
- Load: write buffer[0..3] = 0x11111111, 0x22222222, 0x33333333, 0x44444444; drive PC_AXI=2 -> INSTR_AXI=0x33333333 one cycle later. PC_AXI=N+... (N>512 n/a) / out-of-range pc -> 0.
- Normal run: RUN_REQ with STOP=0; hold STOP=0 for 10 cycles, then STOP=1 -> START_SIGNAL high for 11 cycles, then DONE=1, BUSY=0, CYCLE_COUNT=11, TIMED_OUT=0.
- Stale stop: STOP=1 at RUN_REQ and for 3 cycles, then 0 for 5 cycles, then 1 -> stays in ARM 3 cycles, DONE only after the second STOP rise; CYCLE_COUNT=9.
- Timeout: TIMEOUT=8, STOP held 0 -> DONE=1 and TIMED_OUT=1 after 8 cycles, CYCLE_COUNT=8. STOP=1 on the 8th cycle -> TIMED_OUT=0.
- Load during run: LOAD_EN to address 0 with 0xDEADBEEF while BUSY -> LOAD_ERR=1 and buffer[0] still 0x11111111. Next RUN_REQ clears LOAD_ERR.
- Async reset mid-RUN -> START_SIGNAL, BUSY, DONE and CYCLE_COUNT are 0 before the next clock edge; buffer contents retained.
